// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter: IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin collision handling; default is data-over-fetch priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;

  state_t            state, state_nxt;
  logic              grant_i, grant_d;
  logic              wr;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_d <= 1'b0;
    else if (grant_i || grant_d) last_d <= grant_d;
  end
`endif

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = d_req && (!i_req || !last_d);
`else
        grant_d = d_req;
`endif
        grant_i = i_req && !grant_d;
        if (grant_i || grant_d) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      owner     <= OWN_NONE;
      wr        <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= OWN_DATA;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            wr        <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            owner    <= OWN_FETCH;
            mem_en   <= 1'b1;
            wr       <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        ACCESS: begin
          i_ack <= (owner == OWN_FETCH);
          d_ack <= (owner == OWN_DATA);
        end
        RESP: begin
          owner <= OWN_NONE;
          if (!wr) begin
            if (owner == OWN_FETCH) i_rdata_q <= mem_rdata;
            else                    d_rdata_q <= mem_rdata;
          end
        end
        default: owner <= OWN_NONE;
      endcase
    end
  end

  // Memory data only arrives during RESP, so the ack cycle forwards it while the
  // register captures it at the end of RESP and holds it afterwards.
  assign i_rdata = (i_ack && !wr) ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_ack && !wr) ? mem_rdata : d_rdata_q;

endmodule
